// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI ROM-A to ROM-B page buffer.
package spi_pkg;

    localparam int unsigned PAGE_SIZE_DEF = 256;
    localparam int unsigned PG_LEN_W      = $clog2(PAGE_SIZE_DEF) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_REQ,
        ST_DRAIN,
        ST_WAIT_PROG,
        ST_DONE
    } state_e;

endpackage

// File: rtl/spi_page_ram.sv
// Simple dual-port byte RAM, synchronous write and 1-cycle synchronous read.
module spi_page_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    // No reset on the array or read register so the block maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_page_buffer.sv
// Buffers the read-engine byte stream into page-aligned chunks and hands
// them to the write engine as page-program requests.
module spi_page_buffer
    import spi_pkg::*;
#(
    parameter int unsigned PAGE_SIZE = PAGE_SIZE_DEF,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                      CLK_25M_CKMNG_MAIN_PLD,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         write_start_addr,
    input  logic [7:0]                rd_byte,
    input  logic                      rd_byte_vld,
    output logic                      rd_byte_rdy,
    input  logic                      rd_finish,
    output logic                      pg_req,
    output logic [ADDR_W-1:0]         pg_addr,
    output logic [$clog2(PAGE_SIZE):0] pg_len,
    input  logic                      pg_ack,
    input  logic                      wr_byte_req,
    output logic [7:0]                wr_byte,
    input  logic                      pg_done,
    output logic [CNT_W-1:0]          byte_cnt,
    output logic                      xfer_done,
    output logic                      overflow_err
);

    localparam int unsigned OFF_W = $clog2(PAGE_SIZE);
    localparam int unsigned LEN_W = OFF_W + 1;
    localparam logic [LEN_W-1:0] PAGE_LEN = LEN_W'(PAGE_SIZE);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [LEN_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               fin_q, fin_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               xfer_done_q, xfer_done_d;
    logic               ovf_q, ovf_d;
    logic               pop_q, pop_d;
    logic [7:0]         hold_q, hold_d;

    logic [LEN_W-1:0]   lim;
    logic               accept;
    logic               ram_we;
    logic               ram_re;
    logic [7:0]         ram_rdata;

    spi_page_ram #(
        .DEPTH (PAGE_SIZE),
        .AW    (OFF_W)
    ) u_ram (
        .clk_i   (CLK_25M_CKMNG_MAIN_PLD),
        .we_i    (ram_we),
        .waddr_i (fill_cnt_q[OFF_W-1:0]),
        .wdata_i (rd_byte),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q[OFF_W-1:0]),
        .rdata_o (ram_rdata)
    );

    assign lim         = PAGE_LEN - {1'b0, cur_addr_q[OFF_W-1:0]};
    assign rd_byte_rdy = (state_q == ST_FILL) && (fill_cnt_q < lim);
    assign accept      = rd_byte_rdy && rd_byte_vld;

    assign pg_req       = (state_q == ST_REQ);
    assign pg_addr      = cur_addr_q;
    assign pg_len       = fill_cnt_q;
    // The RAM read register is not reset; the mux keeps wr_byte at 0 after reset.
    assign wr_byte      = pop_q ? ram_rdata : hold_q;
    assign byte_cnt     = byte_cnt_q;
    assign xfer_done    = xfer_done_q;
    assign overflow_err = ovf_q;

    always_ff @(posedge CLK_25M_CKMNG_MAIN_PLD or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            fill_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            fin_q       <= 1'b0;
            byte_cnt_q  <= '0;
            xfer_done_q <= 1'b0;
            ovf_q       <= 1'b0;
            pop_q       <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            fill_cnt_q  <= fill_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            fin_q       <= fin_d;
            byte_cnt_q  <= byte_cnt_d;
            xfer_done_q <= xfer_done_d;
            ovf_q       <= ovf_d;
            pop_q       <= pop_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        fill_cnt_d  = fill_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        fin_d       = fin_q;
        byte_cnt_d  = byte_cnt_q;
        xfer_done_d = xfer_done_q;
        ovf_d       = ovf_q;
        pop_d       = 1'b0;
        hold_d      = pop_q ? ram_rdata : hold_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;

        if ((state_q == ST_FILL) || (state_q == ST_REQ) ||
            (state_q == ST_DRAIN) || (state_q == ST_WAIT_PROG)) begin
            fin_d = fin_q | rd_finish;
        end
        if ((state_q != ST_IDLE) && rd_byte_vld && !rd_byte_rdy) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FILL;
                    cur_addr_d  = write_start_addr;
                    fill_cnt_d  = '0;
                    rd_ptr_d    = '0;
                    fin_d       = 1'b0;
                    byte_cnt_d  = '0;
                    xfer_done_d = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    ram_we     = 1'b1;
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
                // Decide on post-update values so a byte arriving with rd_finish is kept.
                if (fill_cnt_d == lim) begin
                    state_d = ST_REQ;
                end else if (fin_d && (fill_cnt_d != '0)) begin
                    state_d = ST_REQ;
                end else if (fin_d) begin
                    state_d = ST_DONE;
                end
            end
            ST_REQ: begin
                if (pg_ack) begin
                    state_d  = ST_DRAIN;
                    rd_ptr_d = '0;
                end
            end
            ST_DRAIN: begin
                if (wr_byte_req && (rd_ptr_q < fill_cnt_q)) begin
                    ram_re   = 1'b1;
                    pop_d    = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_d == fill_cnt_q) begin
                        state_d = ST_WAIT_PROG;
                    end
                end
            end
            ST_WAIT_PROG: begin
                if (pg_done) begin
                    cur_addr_d = cur_addr_q + ADDR_W'(fill_cnt_q);
                    fill_cnt_d = '0;
                    rd_ptr_d   = '0;
                    state_d    = fin_d ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                xfer_done_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_page_buffer.sv
// Directed scoreboard bench for spi_page_buffer with a reference page-split model.
module tb_spi_page_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] write_start_addr;
    logic [7:0]  rd_byte;
    logic        rd_byte_vld;
    logic        rd_byte_rdy;
    logic        rd_finish;
    logic        pg_req;
    logic [31:0] pg_addr;
    logic [8:0]  pg_len;
    logic        pg_ack;
    logic        wr_byte_req;
    logic [7:0]  wr_byte;
    logic        pg_done;
    logic [15:0] byte_cnt;
    logic        xfer_done;
    logic        overflow_err;

    always #20 clk = ~clk;

    spi_page_buffer #(
        .PAGE_SIZE (256),
        .ADDR_W    (32),
        .CNT_W     (16)
    ) dut (
        .CLK_25M_CKMNG_MAIN_PLD (clk),
        .rst                    (rst),
        .start                  (start),
        .write_start_addr       (write_start_addr),
        .rd_byte                (rd_byte),
        .rd_byte_vld            (rd_byte_vld),
        .rd_byte_rdy            (rd_byte_rdy),
        .rd_finish              (rd_finish),
        .pg_req                 (pg_req),
        .pg_addr                (pg_addr),
        .pg_len                 (pg_len),
        .pg_ack                 (pg_ack),
        .wr_byte_req            (wr_byte_req),
        .wr_byte                (wr_byte),
        .pg_done                (pg_done),
        .byte_cnt               (byte_cnt),
        .xfer_done              (xfer_done),
        .overflow_err           (overflow_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
    } page_t;

    page_t      pg_q[$];
    logic [7:0] data_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference split of a transfer into pages that never cross a 256-byte boundary.
    task automatic push_pages(input logic [31:0] addr, input int unsigned n);
        logic [31:0] a;
        int unsigned left, lim, len;
        a    = addr;
        left = n;
        while (left > 0) begin
            lim  = 256 - (a % 256);
            len  = (left < lim) ? left : lim;
            pg_q.push_back('{addr: a, len: len});
            a    = a + len;
            left = left - len;
        end
    endtask

    task automatic do_start(input logic [31:0] addr);
        @(negedge clk);
        write_start_addr = addr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int unsigned n, input logic [7:0] base,
                        input logic [7:0] step, input bit fin_last);
        int unsigned i, t;
        logic [7:0]  b;
        i = 0;
        t = 0;
        b = base;
        @(negedge clk);
        while (i < n && t < 5000) begin
            if (rd_byte_rdy) begin
                rd_byte     = b;
                rd_byte_vld = 1'b1;
                rd_finish   = fin_last && (i == n - 1);
                data_q.push_back(b);
                b = b + step;
                i++;
            end else begin
                rd_byte_vld = 1'b0;
                rd_finish   = 1'b0;
                t++;
            end
            @(negedge clk);
        end
        rd_byte_vld = 1'b0;
        rd_finish   = 1'b0;
        if (i < n) chk("feed_timeout", i, n);
    endtask

    task automatic serve(input int unsigned npages, input bit extra_pop);
        page_t       exp_pg;
        logic [7:0]  d;
        int unsigned t;
        for (int unsigned p = 0; p < npages; p++) begin
            t = 0;
            while (!pg_req && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (!pg_req) begin
                chk("pg_req_timeout", {31'd0, pg_req}, 32'd1);
                return;
            end
            if (pg_q.size() == 0) begin
                chk("unexpected_page", pg_addr, 32'hFFFF_FFFF);
                return;
            end
            exp_pg = pg_q.pop_front();
            chk("pg_addr", pg_addr, exp_pg.addr);
            chk("pg_len", {23'd0, pg_len}, exp_pg.len);
            chk("rdy_in_req", {31'd0, rd_byte_rdy}, 32'd0);
            repeat (2) @(negedge clk);
            chk("pg_req_held", {31'd0, pg_req}, 32'd1);
            chk("pg_addr_held", pg_addr, exp_pg.addr);
            pg_ack = 1'b1;
            @(negedge clk);
            pg_ack = 1'b0;
            chk("pg_req_drop", {31'd0, pg_req}, 32'd0);
            d = 8'h00;
            for (int unsigned j = 0; j < exp_pg.len; j++) begin
                wr_byte_req = 1'b1;
                @(negedge clk);
                if (data_q.size() == 0) begin
                    chk("data_underrun", {24'd0, wr_byte}, 32'hFFFF_FFFF);
                end else begin
                    d = data_q.pop_front();
                    chk("wr_byte", {24'd0, wr_byte}, {24'd0, d});
                end
            end
            wr_byte_req = 1'b0;
            if (extra_pop) begin
                wr_byte_req = 1'b1;
                @(negedge clk);
                wr_byte_req = 1'b0;
                @(negedge clk);
                chk("wr_byte_hold", {24'd0, wr_byte}, {24'd0, d});
            end
            @(negedge clk);
            chk("rdy_in_wait_prog", {31'd0, rd_byte_rdy}, 32'd0);
            pg_done = 1'b1;
            @(negedge clk);
            pg_done = 1'b0;
        end
    endtask

    task automatic wait_done();
        int unsigned t;
        t = 0;
        while (!xfer_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("xfer_done", {31'd0, xfer_done}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"},     {31'd0, rd_byte_rdy},  32'd0);
        chk({tag, "_pg_req"},  {31'd0, pg_req},       32'd0);
        chk({tag, "_pg_addr"}, pg_addr,               32'd0);
        chk({tag, "_pg_len"},  {23'd0, pg_len},       32'd0);
        chk({tag, "_wr_byte"}, {24'd0, wr_byte},      32'd0);
        chk({tag, "_cnt"},     {16'd0, byte_cnt},     32'd0);
        chk({tag, "_done"},    {31'd0, xfer_done},    32'd0);
        chk({tag, "_ovf"},     {31'd0, overflow_err}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        write_start_addr = '0;
        rd_byte = '0;
        rd_byte_vld = 1'b0;
        rd_finish = 1'b0;
        pg_ack = 1'b0;
        wr_byte_req = 1'b0;
        pg_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // 12 bytes of 0xAA, finish with the last byte.
        do_start(32'h0);
        push_pages(32'h0, 12);
        fork
            feed(12, 8'hAA, 8'h00, 1'b1);
            serve(1, 1'b1);
        join
        wait_done();
        chk("t1_cnt", {16'd0, byte_cnt}, 32'd12);

        // 300 incrementing bytes: full page then remainder.
        do_start(32'h0);
        push_pages(32'h0, 300);
        fork
            feed(300, 8'h00, 8'h01, 1'b1);
            serve(2, 1'b0);
        join
        wait_done();
        chk("t2_cnt", {16'd0, byte_cnt}, 32'd300);

        // Unaligned start: first page limited to 16 bytes.
        do_start(32'hF0);
        push_pages(32'hF0, 20);
        fork
            feed(20, 8'h30, 8'h07, 1'b1);
            serve(2, 1'b0);
        join
        wait_done();
        chk("t3_cnt", {16'd0, byte_cnt}, 32'd20);

        // Exactly one full page with finish on the last byte.
        do_start(32'h0);
        push_pages(32'h0, 256);
        fork
            feed(256, 8'hFF, 8'hFD, 1'b1);
            serve(1, 1'b0);
        join
        wait_done();
        repeat (5) @(negedge clk);
        chk("t4_no_extra_req", {31'd0, pg_req}, 32'd0);
        chk("t4_cnt", {16'd0, byte_cnt}, 32'd256);

        // Overflow while waiting for ack; finish arrives during REQ.
        do_start(32'hFE);
        push_pages(32'hFE, 2);
        feed(2, 8'h5A, 8'h01, 1'b0);
        rd_byte = 8'hEE;
        rd_byte_vld = 1'b1;
        repeat (3) @(negedge clk);
        rd_byte_vld = 1'b0;
        chk("t5_ovf", {31'd0, overflow_err}, 32'd1);
        chk("t5_cnt", {16'd0, byte_cnt}, 32'd2);
        rd_finish = 1'b1;
        @(negedge clk);
        rd_finish = 1'b0;
        serve(1, 1'b0);
        wait_done();
        chk("t5_ovf_sticky", {31'd0, overflow_err}, 32'd1);
        do_start(32'h40);
        chk("t5_ovf_clear", {31'd0, overflow_err}, 32'd0);
        chk("t5_done_clear", {31'd0, xfer_done}, 32'd0);
        rd_finish = 1'b1;
        @(negedge clk);
        rd_finish = 1'b0;
        wait_done();
        chk("t5_empty_cnt", {16'd0, byte_cnt}, 32'd0);
        chk("t5_empty_no_req", {31'd0, pg_req}, 32'd0);

        // Reset in the middle of draining, then a fresh transfer.
        do_start(32'h0);
        feed(8, 8'h10, 8'h01, 1'b1);
        begin
            int unsigned t;
            t = 0;
            while (!pg_req && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("t6_req_seen", {31'd0, pg_req}, 32'd1);
        end
        pg_ack = 1'b1;
        @(negedge clk);
        pg_ack = 1'b0;
        wr_byte_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wr_byte_req = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        data_q.delete();
        pg_q.delete();
        @(negedge clk);
        do_start(32'h200);
        push_pages(32'h200, 4);
        fork
            feed(4, 8'hC3, 8'h11, 1'b1);
            serve(1, 1'b0);
        join
        wait_done();
        chk("t6_cnt", {16'd0, byte_cnt}, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
